// File: rtl/elgamal_decryptor.sv
// elgamal_decryptor
//   ElGamal receive endpoint. Accepts group parameters (p, g), derives a
//   private key x from a Galois LFSR seeded with p^g, publishes y = g^x mod p,
//   then decrypts ciphertext pairs (c1, c2) into m = c2 * c1^(p-1-x) mod p.
//   All arithmetic runs on one shared bit-serial modular multiplier; the
//   exponentiation always performs both multiplies per exponent bit, so its
//   latency does not depend on the data.
//
//   Optional build macro: ELGAMAL_KEY_LOAD_EN adds key_tdata/key_tvalid so a
//   private key can be loaded alongside the parameters instead of generated.
//
// Ports
//   clk, rst                      clock (rising edge), async active-high reset
//   input_first_*                 AXI-S, p in IDLE, c1 in DEC_IDLE
//   input_second_*                AXI-S, g in IDLE, c2 in DEC_IDLE
//   output_key_tvalid/tready      handshake for the public-key tuple
//   output_p/g/y_tdata            public-key tuple (p, g, y)
//   output_m_*                    AXI-S plaintext, tuser flags range error
//   key_tdata, key_tvalid         optional loaded private key
//   param_err                     last parameter transfer was rejected
module elgamal_decryptor #(
    parameter int unsigned     SIZE = 64,
    parameter logic [SIZE-1:0] TAPS = SIZE'(64'hD800000000000000)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] input_first_tdata,
    input  logic            input_first_tvalid,
    output logic            input_first_tready,
    input  logic [SIZE-1:0] input_second_tdata,
    input  logic            input_second_tvalid,
    output logic            input_second_tready,
    output logic            output_key_tvalid,
    input  logic            output_key_tready,
    output logic [SIZE-1:0] output_p_tdata,
    output logic [SIZE-1:0] output_g_tdata,
    output logic [SIZE-1:0] output_y_tdata,
    output logic [SIZE-1:0] output_m_tdata,
    output logic            output_m_tvalid,
    input  logic            output_m_tready,
    output logic            output_m_tuser,
`ifdef ELGAMAL_KEY_LOAD_EN
    input  logic [SIZE-1:0] key_tdata,
    input  logic            key_tvalid,
`endif
    output logic            param_err
);

    localparam int unsigned BW = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef enum logic [2:0] {
        IDLE, KEYGEN, PUBKEY, KEY_OUT, DEC_IDLE, DEC_EXP, DEC_MUL, DEC_OUT
    } state_t;

    state_t          r_state;
    logic [SIZE-1:0] r_p, r_g, r_x, r_y, r_c1, r_c2, r_dexp, r_lfsr;
    logic [SIZE-1:0] r_exp_r, r_acc, r_m;
    logic [BW-1:0]   r_mbit, r_ebit;
    logic            r_phase, r_mload, r_fin;
    logic            r_key_valid, r_m_valid, r_m_user, r_param_err;

    logic            w_accept, w_param_ok, w_cand_ok, w_ct_ok;
    logic [SIZE-1:0] w_seed, w_lfsr_next, w_base, w_exp_e, w_mul_a, w_mul_b;
    logic [SIZE:0]   w_dbl, w_sum, w_p1;
    logic [SIZE-1:0] w_dbl_red, w_sum_red, w_step, w_exp_next;
`ifdef ELGAMAL_KEY_LOAD_EN
    logic            w_key_ok;
`endif

    // Joint transfer: both channels accept together, only while waiting
    assign w_accept = ((r_state == IDLE) || (r_state == DEC_IDLE)) &&
                      input_first_tvalid && input_second_tvalid && !rst;
    assign input_first_tready  = w_accept;
    assign input_second_tready = w_accept;

    assign w_param_ok = (input_first_tdata >= SIZE'(3)) &&
                        (input_second_tdata != '0) &&
                        (input_second_tdata < input_first_tdata);
    assign w_seed     = ((input_first_tdata ^ input_second_tdata) == '0) ?
                        SIZE'(1) : (input_first_tdata ^ input_second_tdata);
    assign w_ct_ok    = (input_first_tdata != '0) && (input_first_tdata < r_p) &&
                        (input_second_tdata < r_p);
`ifdef ELGAMAL_KEY_LOAD_EN
    assign w_key_ok   = key_tvalid && (key_tdata != '0) &&
                        (key_tdata <= input_first_tdata - SIZE'(2));
`endif

    // Galois LFSR, right-shifting; candidate must lie in [1, p-2]
    assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
    assign w_cand_ok   = (w_lfsr_next != '0) && (w_lfsr_next <= r_p - SIZE'(2));

    // Exponentiation operands: keygen uses (g, x), decryption (c1, p-1-x)
    assign w_base  = (r_state == PUBKEY) ? r_g : r_c1;
    assign w_exp_e = (r_state == PUBKEY) ? r_x : r_dexp;

    // Multiplier operand select: square, multiply by base, or final c2*s'
    always_comb begin
        w_mul_a = r_exp_r;
        w_mul_b = r_exp_r;
        if (r_state == DEC_MUL) begin
            w_mul_a = r_c2;
        end else if (r_phase) begin
            w_mul_b = w_base;
        end
    end

    // One multiplier iteration: r = 2r mod p, then r = r + a mod p if bit set
    assign w_p1      = {1'b0, r_p};
    assign w_dbl     = {r_acc, 1'b0};
    assign w_dbl_red = SIZE'((w_dbl >= w_p1) ? (w_dbl - w_p1) : w_dbl);
    assign w_sum     = {1'b0, w_dbl_red} + {1'b0, w_mul_a};
    assign w_sum_red = SIZE'((w_sum >= w_p1) ? (w_sum - w_p1) : w_sum);
    assign w_step    = w_mul_b[r_mbit] ? w_sum_red : w_dbl_red;

    // After the base multiply, keep the product only when the exponent bit is set
    assign w_exp_next = w_exp_e[r_ebit] ? w_step : r_exp_r;

    // Control, key storage and arithmetic sequencing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_p         <= '0;
            r_g         <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_c1        <= '0;
            r_c2        <= '0;
            r_dexp      <= '0;
            r_lfsr      <= SIZE'(1);
            r_exp_r     <= '0;
            r_acc       <= '0;
            r_m         <= '0;
            r_mbit      <= '0;
            r_ebit      <= '0;
            r_phase     <= 1'b0;
            r_mload     <= 1'b0;
            r_fin       <= 1'b0;
            r_key_valid <= 1'b0;
            r_m_valid   <= 1'b0;
            r_m_user    <= 1'b0;
            r_param_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_param_ok) begin
                            r_param_err <= 1'b0;
                            r_p         <= input_first_tdata;
                            r_g         <= input_second_tdata;
                            r_lfsr      <= w_seed;
                            r_exp_r     <= SIZE'(1);
                            r_ebit      <= BW'(SIZE - 1);
                            r_phase     <= 1'b0;
                            r_mload     <= 1'b1;
                            r_fin       <= 1'b0;
`ifdef ELGAMAL_KEY_LOAD_EN
                            if (w_key_ok) begin
                                r_x     <= key_tdata;
                                r_state <= PUBKEY;
                            end else
`endif
                            r_state <= KEYGEN;
                        end else begin
                            r_param_err <= 1'b1;
                        end
                    end
                end
                KEYGEN: begin
                    r_lfsr <= w_lfsr_next;
                    if (w_cand_ok) begin
                        r_x     <= w_lfsr_next;
                        r_exp_r <= SIZE'(1);
                        r_ebit  <= BW'(SIZE - 1);
                        r_phase <= 1'b0;
                        r_mload <= 1'b1;
                        r_state <= PUBKEY;
                    end
                end
                PUBKEY, DEC_EXP, DEC_MUL: begin
                    if (r_fin) begin
                        // Extra cycle between the final product and m becoming visible
                        r_fin     <= 1'b0;
                        r_m       <= r_acc;
                        r_m_user  <= 1'b0;
                        r_m_valid <= 1'b1;
                        r_state   <= DEC_OUT;
                    end else if (r_mload) begin
                        r_acc   <= '0;
                        r_mbit  <= BW'(SIZE - 1);
                        r_mload <= 1'b0;
                    end else begin
                        r_acc <= w_step;
                        if (r_mbit != '0) begin
                            r_mbit <= r_mbit - BW'(1);
                        end else begin
                            r_mload <= 1'b1;
                            if (r_state == DEC_MUL) begin
                                r_fin <= 1'b1;
                            end else if (!r_phase) begin
                                r_exp_r <= w_step;
                                r_phase <= 1'b1;
                            end else begin
                                r_exp_r <= w_exp_next;
                                r_phase <= 1'b0;
                                if (r_ebit != '0) begin
                                    r_ebit <= r_ebit - BW'(1);
                                end else if (r_state == PUBKEY) begin
                                    r_y         <= w_exp_next;
                                    r_key_valid <= 1'b1;
                                    r_state     <= KEY_OUT;
                                end else begin
                                    r_state <= DEC_MUL;
                                end
                            end
                        end
                    end
                end
                KEY_OUT: begin
                    if (output_key_tready) begin
                        r_key_valid <= 1'b0;
                        r_state     <= DEC_IDLE;
                    end
                end
                DEC_IDLE: begin
                    if (w_accept) begin
                        r_c1   <= input_first_tdata;
                        r_c2   <= input_second_tdata;
                        r_dexp <= r_p - SIZE'(1) - r_x;
                        if (w_ct_ok) begin
                            r_exp_r <= SIZE'(1);
                            r_ebit  <= BW'(SIZE - 1);
                            r_phase <= 1'b0;
                            r_mload <= 1'b1;
                            r_fin   <= 1'b0;
                            r_state <= DEC_EXP;
                        end else begin
                            r_m       <= '0;
                            r_m_user  <= 1'b1;
                            r_m_valid <= 1'b1;
                            r_state   <= DEC_OUT;
                        end
                    end
                end
                DEC_OUT: begin
                    if (output_m_tready) begin
                        r_m_valid <= 1'b0;
                        r_state   <= DEC_IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign output_key_tvalid = r_key_valid;
    assign output_p_tdata    = r_p;
    assign output_g_tdata    = r_g;
    assign output_y_tdata    = r_y;
    assign output_m_tdata    = r_m;
    assign output_m_tvalid   = r_m_valid;
    assign output_m_tuser    = r_m_user;
    assign param_err         = r_param_err;

endmodule

// File: tb/tb_elgamal_decryptor.sv
// tb_elgamal_decryptor
//   Self-checking bench for elgamal_decryptor at SIZE=8, TAPS=8'hB8, p=23.
//   Fixed ciphertext table for the LFSR key of (23,5), hand-written
//   rejection/backpressure/reset sequences, and randomized reseeded
//   encrypt/decrypt round trips against a plain-arithmetic model.
module tb_elgamal_decryptor;

    localparam int unsigned W  = 8;
    localparam int          E  = 2 * W * (W + 1);
    localparam logic [7:0]  TP = 8'hB8;
    localparam int          P  = 23;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in1_data, in2_data;
    logic         in1_valid, in2_valid, in1_ready, in2_ready;
    logic         key_valid, key_ready;
    logic [W-1:0] p_data, g_data, y_data, m_data;
    logic         m_valid, m_ready, m_user, perr;
`ifdef ELGAMAL_KEY_LOAD_EN
    logic [W-1:0] ld_key;
    logic         ld_key_valid;
`endif

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    elgamal_decryptor #(.SIZE(W), .TAPS(TP)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .input_first_tdata   (in1_data),
        .input_first_tvalid  (in1_valid),
        .input_first_tready  (in1_ready),
        .input_second_tdata  (in2_data),
        .input_second_tvalid (in2_valid),
        .input_second_tready (in2_ready),
        .output_key_tvalid   (key_valid),
        .output_key_tready   (key_ready),
        .output_p_tdata      (p_data),
        .output_g_tdata      (g_data),
        .output_y_tdata      (y_data),
        .output_m_tdata      (m_data),
        .output_m_tvalid     (m_valid),
        .output_m_tready     (m_ready),
        .output_m_tuser      (m_user),
`ifdef ELGAMAL_KEY_LOAD_EN
        .key_tdata           (ld_key),
        .key_tvalid          (ld_key_valid),
`endif
        .param_err           (perr)
    );

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Reference arithmetic, plain integer math
    function automatic int powmod(input int b, input int e, input int p);
        int r = 1;
        for (int i = 0; i < e; i++) r = (r * (b % p)) % p;
        return r;
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return (v >> 1) ^ (v[0] ? TP : 8'h00);
    endfunction

    // Predicts the private key and how many LFSR candidates are tried
    task automatic model_key(input int p, input int g, output int x, output int n);
        logic [7:0] v;
        v = 8'(p) ^ 8'(g);
        if (v == 8'h00) v = 8'h01;
        n = 0;
        x = 0;
        for (int i = 0; i < 300; i++) begin
            v = lfsr_step(v);
            n++;
            if (int'(v) >= 1 && int'(v) <= p - 2) begin
                x = int'(v);
                break;
            end
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge
    task automatic send_pair(input int a, input int b, output int hs);
        bit ok = 0;
        in1_data = 8'(a); in2_data = 8'(b);
        in1_valid = 1'b1; in2_valid = 1'b1;
        #1;
        for (int i = 0; i < 1000; i++) begin
            if (in1_ready && in2_ready) begin
                @(posedge clk); #1;
                hs = cyc;
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        in1_valid = 1'b0; in2_valid = 1'b0;
        chk("pair_accepted", ok, 1);
    endtask

    task automatic wait_key(input int hs, output int lat);
        bit ok = 0;
        lat = -1;
        for (int i = 0; i < 2000; i++) begin
            if (key_valid) begin lat = cyc - hs + 1; ok = 1; break; end
            @(posedge clk); #1;
        end
        chk("key_valid_seen", ok, 1);
    endtask

    task automatic decrypt(input int c1, input int c2, output int m, output int u, output int lat);
        int hs;
        bit ok = 0;
        send_pair(c1, c2, hs);
        lat = -1; m = -1; u = -1;
        for (int i = 0; i < 2000; i++) begin
            if (m_valid) begin
                lat = cyc - hs + 1; m = int'(m_data); u = int'(m_user); ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("m_valid_seen", ok, 1);
        if (ok && m_ready) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    typedef struct {
        int c1; int c2; int m; int user; int lat;
    } vec_t;
    vec_t vecs[9];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int hs, lat, x, n, m, u, y_m, found, bad, rdy_seen, seen, g, k, c1, c2, nm, mm;
        int m0, u0;

        // Key of (23,5): seed 18 -> first LFSR step 9 -> x=9, y=11, d=13
        vecs[0] = '{10, 14,  3, 0, E + W + 3};
        vecs[1] = '{ 0,  5,  0, 1, 1};
        vecs[2] = '{10,  0,  0, 0, E + W + 3};
        vecs[3] = '{23,  1,  0, 1, 1};
        vecs[4] = '{ 1, 22, 22, 0, E + W + 3};
        vecs[5] = '{ 1, 23,  0, 1, 1};
        vecs[6] = '{22,  1, 22, 0, E + W + 3};
        vecs[7] = '{ 5, 11,  1, 0, E + W + 3};
        vecs[8] = '{ 2,  3, 12, 0, E + W + 3};

        rst = 1'b1;
        in1_data = '0; in2_data = '0; in1_valid = 1'b0; in2_valid = 1'b0;
        key_ready = 1'b1; m_ready = 1'b1;
`ifdef ELGAMAL_KEY_LOAD_EN
        ld_key = '0; ld_key_valid = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        in1_valid = 1'b1; in2_valid = 1'b1;
        #1;
        chk("reset_tready", int'(in1_ready) + int'(in2_ready), 0);
        chk("reset_valids", int'(key_valid) + int'(m_valid), 0);
        chk("reset_tdata", int'(p_data) + int'(g_data) + int'(y_data) + int'(m_data), 0);
        chk("reset_flags", int'(m_user) + int'(perr), 0);
        in1_valid = 1'b0; in2_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Parameter rejection
        send_pair(2, 5, hs);
        chk("perr_p2", perr, 1);
        send_pair(23, 23, hs);
        chk("perr_g_eq_p", perr, 1);
        send_pair(23, 0, hs);
        chk("perr_g0", perr, 1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            seen += int'(key_valid);
            @(posedge clk); #1;
        end
        chk("no_key_after_reject", seen, 0);

        // Valid parameters, LFSR key
        send_pair(23, 5, hs);
        chk("perr_cleared", perr, 0);
        model_key(23, 5, x, n);
        wait_key(hs, lat);
        chk("key_latency", lat, n + E + 1);
        chk("key_p", p_data, 23);
        chk("key_g", g_data, 5);
        chk("key_y", y_data, powmod(5, x, P));
        @(posedge clk); #1;
        chk("key_valid_drop", key_valid, 0);

        // Ciphertext table
        for (int i = 0; i < 9; i++) begin
            decrypt(vecs[i].c1, vecs[i].c2, m, u, lat);
            chk("tbl_m", m, vecs[i].m);
            chk("tbl_user", u, vecs[i].user);
            chk("tbl_latency", lat, vecs[i].lat);
            chk("tbl_m_valid_drop", m_valid, 0);
        end

        // Backpressure on the plaintext output
        m_ready = 1'b0;
        decrypt(5, 11, m0, u0, lat);
        chk("bp_m", m0, 1);
        in1_data = 8'd2; in2_data = 8'd3; in1_valid = 1'b1; in2_valid = 1'b1;
        bad = 0; rdy_seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (!m_valid || int'(m_data) != m0 || int'(m_user) != u0) bad++;
            rdy_seen += int'(in1_ready) + int'(in2_ready);
        end
        chk("bp_stable", bad, 0);
        chk("bp_in_ready", rdy_seen, 0);
        in1_valid = 1'b0; in2_valid = 1'b0;
        m_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_drop", m_valid, 0);

        // Reset while exponentiating
        send_pair(10, 14, hs);
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_valids", int'(key_valid) + int'(m_valid), 0);
        chk("rst_mid_tdata", int'(p_data) + int'(g_data) + int'(y_data) + int'(m_data), 0);
        chk("rst_mid_flags", int'(m_user) + int'(perr) + int'(in1_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        send_pair(23, 7, hs);
        model_key(23, 7, x, n);
        wait_key(hs, lat);
        chk("rst_regen_latency", lat, n + E + 1);
        chk("rst_regen_y", y_data, powmod(7, x, P));
        @(posedge clk); #1;
        decrypt(powmod(7, 3, P), (4 * powmod(powmod(7, x, P), 3, P)) % P, m, u, lat);
        chk("rst_regen_m", m, 4);

`ifdef ELGAMAL_KEY_LOAD_EN
        // Loaded private key skips the LFSR search
        pulse_reset();
        ld_key = 8'd6; ld_key_valid = 1'b1;
        send_pair(23, 5, hs);
        ld_key_valid = 1'b0;
        wait_key(hs, lat);
        chk("load_latency", lat, E + 1);
        chk("load_y", y_data, 8);
        @(posedge clk); #1;
        decrypt(10, 14, m, u, lat);
        chk("load_m", m, 10);
        chk("load_m_latency", lat, E + W + 3);
`endif

        // Reseeded LFSR keys with encrypt/decrypt round trips
        for (int r = 0; r < 16; r++) begin
            pulse_reset();
            g = (r == 0) ? 5 : int'($urandom_range(22, 1));
            send_pair(P, g, hs);
            model_key(P, g, x, n);
            y_m = powmod(g, x, P);
            wait_key(hs, lat);
            chk("rnd_key_latency", lat, n + E + 1);
            chk("rnd_y", y_data, y_m);
            found = 0;
            for (int xx = 1; xx <= P - 2; xx++)
                if (powmod(g, xx, P) == int'(y_data)) found++;
            chk("rnd_y_brute", (found > 0) ? 1 : 0, 1);
            @(posedge clk); #1;
            nm = (r == 0) ? 22 : 3;
            for (int j = 0; j < nm; j++) begin
                mm = (r == 0) ? j + 1 : int'($urandom_range(22, 1));
                k  = int'($urandom_range(21, 1));
                c1 = powmod(g, k, P);
                c2 = (mm * powmod(y_m, k, P)) % P;
                decrypt(c1, c2, m, u, lat);
                chk("rnd_roundtrip_m", m, mm);
                chk("rnd_roundtrip_user", u, 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
